// File: rtl/clkrst_sequencer.sv
// clkrst_sequencer
//   Clock/reset supervisor. It holds reset for a power-on interval, then
//   configures the pixel PLL for the selected chip and pulses its reset.
//   After a filtered lock it releases the domain resets one stage at a time.
//   In RUN it re-sequences on lock loss or on a debounced chip request change.
// Ports
//   sys_clock   free-running board clock (all logic on rising edge)
//   rst         synchronous active-high reset
//   chip_req    requested chip code (async, synced here)
//   pll_locked  PLL lock (async, two-flop synced here)
//   cfg_done    one-cycle pulse from the PLL config engine
//   cfg_start   one-cycle pulse: start reconfiguration for chip
//   pll_reset   PLL reset
//   chip        active chip code
//   domain_rst  staged active-high resets, bit 0 released first
//   ready       high only in RUN
//   fault       sticky lock failure, cleared only by rst
module clkrst_sequencer #(
  parameter int         NUM_DOMAINS  = 2,
  parameter int         POR_BITS     = 22,
  parameter int         PLL_RST_CYC  = 64,
  parameter int         LOCK_FILTER  = 16,
  parameter int         LOCK_TIMEOUT = 1 << 20,
  parameter int         MAX_RETRIES  = 3,
  parameter int         STAGE_DELAY  = 256,
  parameter int         CHIP_STABLE  = 1024,
  parameter logic [1:0] CHIP_DEFAULT = 2'b01
) (
  input  logic                   sys_clock,
  input  logic                   rst,
  input  logic [1:0]             chip_req,
  input  logic                   pll_locked,
  input  logic                   cfg_done,
  output logic                   cfg_start,
  output logic                   pll_reset,
  output logic [1:0]             chip,
  output logic [NUM_DOMAINS-1:0] domain_rst,
  output logic                   ready,
  output logic                   fault
);

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int POR_CYC = 1 << (POR_BITS - 1);
  localparam int CNT_MAX = imax(imax(POR_CYC - 1, PLL_RST_CYC - 1),
                                imax(LOCK_TIMEOUT - 1, STAGE_DELAY - 1));
  localparam int CW = imax(1, $clog2(CNT_MAX + 1));
  localparam int SW = imax(1, $clog2(NUM_DOMAINS));
  localparam int RW = imax(1, $clog2(MAX_RETRIES + 1));
  localparam int LW = imax(1, $clog2(LOCK_FILTER));
  localparam int HW = imax(1, $clog2(CHIP_STABLE + 1));

  localparam logic [CW-1:0] POR_LAST = CW'(POR_CYC - 1);
  localparam logic [CW-1:0] PR_LAST  = CW'(PLL_RST_CYC - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] SD_LAST  = CW'(STAGE_DELAY - 1);
  localparam logic [CW-1:0] CNT_TOP  = CW'(CNT_MAX);
  localparam logic [SW-1:0] STG_LAST = SW'(NUM_DOMAINS - 1);
  localparam logic [RW-1:0] RTRY_MAX = RW'(MAX_RETRIES);
  localparam logic [LW-1:0] LK_LAST  = LW'(LOCK_FILTER - 1);
  localparam logic [HW-1:0] CH_TOP   = HW'(CHIP_STABLE);

  typedef enum logic [2:0] {
    S_POR, S_CFG, S_PLL_RST, S_WAIT_LOCK, S_RELEASE, S_RUN, S_FAULT
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [SW-1:0]   stg, stg_n;
  logic [RW-1:0]   rtry, rtry_n, rtry_inc;
  logic [1:0]      tgt, tgt_n;

  // input synchronisers
  logic            lk_meta, lk_s;
  logic [1:0]      ch_meta, ch_s, ch_prev;

  // lock filter / chip debounce
  logic [LW-1:0]   lk_cnt;
  logic            lk_ok;
  logic [HW-1:0]   ch_cnt, ch_cnt_n;
  logic            ch_hit, ch_same, chip_go;

  // registered-output next values
  logic                   cfg_start_d, pll_reset_d, ready_d, fault_d;
  logic [1:0]             chip_d;
  logic [NUM_DOMAINS-1:0] domain_rst_d;

  // lk_ok is combinational on the synced level so a low cycle drops it at once
  assign lk_ok = lk_s && (lk_cnt == LK_LAST);

  // count of consecutive cycles the synced request has held one value != chip
  always_comb begin
    ch_hit  = (ch_s != chip);
    ch_same = (ch_s == ch_prev);
    if (!ch_hit)                ch_cnt_n = '0;
    else if (!ch_same)          ch_cnt_n = HW'(1);
    else if (ch_cnt == CH_TOP)  ch_cnt_n = ch_cnt;
    else                        ch_cnt_n = ch_cnt + 1'b1;
    chip_go = ch_hit && (ch_cnt_n == CH_TOP);
  end

  // state register, counters, synchronisers and registered outputs
  always_ff @(posedge sys_clock) begin
    if (rst) begin
      state      <= S_POR;
      cnt        <= '0;
      stg        <= '0;
      rtry       <= '0;
      tgt        <= CHIP_DEFAULT;
      lk_meta    <= 1'b0;
      lk_s       <= 1'b0;
      lk_cnt     <= '0;
      ch_meta    <= CHIP_DEFAULT;
      ch_s       <= CHIP_DEFAULT;
      ch_prev    <= CHIP_DEFAULT;
      ch_cnt     <= '0;
      cfg_start  <= 1'b0;
      pll_reset  <= 1'b1;
      chip       <= CHIP_DEFAULT;
      domain_rst <= '1;
      ready      <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      stg        <= stg_n;
      rtry       <= rtry_n;
      tgt        <= tgt_n;
      lk_meta    <= pll_locked;
      lk_s       <= lk_meta;
      if (!lk_s)                 lk_cnt <= '0;
      else if (lk_cnt != LK_LAST) lk_cnt <= lk_cnt + 1'b1;
      ch_meta    <= chip_req;
      ch_s       <= ch_meta;
      ch_prev    <= ch_s;
      // debounce only runs in RUN; re-entering RUN restarts it
      ch_cnt     <= (state == S_RUN) ? ch_cnt_n : '0;
      cfg_start  <= cfg_start_d;
      pll_reset  <= pll_reset_d;
      chip       <= chip_d;
      domain_rst <= domain_rst_d;
      ready      <= ready_d;
      fault      <= fault_d;
    end
  end

  // next-state logic
  always_comb begin
    state_n  = state;
    cnt_n    = (cnt == CNT_TOP) ? cnt : cnt + 1'b1;
    stg_n    = stg;
    rtry_n   = rtry;
    tgt_n    = tgt;
    rtry_inc = rtry + 1'b1;
    unique case (state)
      S_POR:       if (cnt == POR_LAST) state_n = S_CFG;
      S_CFG:       if (cfg_done) state_n = S_PLL_RST;
      S_PLL_RST:   if (cnt == PR_LAST) state_n = S_WAIT_LOCK;
      S_WAIT_LOCK: begin
        if (lk_ok) begin
          state_n = S_RELEASE;
          stg_n   = '0;
        end else if (cnt == TO_LAST) begin
          rtry_n  = rtry_inc;
          state_n = (rtry_inc == RTRY_MAX) ? S_FAULT : S_PLL_RST;
        end
      end
      S_RELEASE: begin
        if (!lk_ok) state_n = S_PLL_RST;
        else if (cnt == SD_LAST) begin
          if (stg == STG_LAST) state_n = S_RUN;
          else begin
            stg_n = stg + 1'b1;
            cnt_n = '0;
          end
        end
      end
      S_RUN: begin
        rtry_n = '0;
        // lock loss takes priority; a pending chip change waits for RUN again
        if (!lk_ok) state_n = S_PLL_RST;
        else if (chip_go) begin
          state_n = S_CFG;
          tgt_n   = ch_s;
        end
      end
      S_FAULT:     state_n = S_FAULT;
      default:     state_n = S_POR;
    endcase
    if (state_n != state) cnt_n = '0;
  end

  // output logic, evaluated on the next state so outputs track the state flop
  always_comb begin
    cfg_start_d = (state_n == S_CFG) && (state != S_CFG);
    pll_reset_d = (state_n == S_POR) || (state_n == S_CFG) ||
                  (state_n == S_PLL_RST) || (state_n == S_FAULT);
    ready_d     = (state_n == S_RUN);
    fault_d     = (state_n == S_FAULT);
    chip_d      = (state_n == S_CFG) ? tgt_n : chip;
  end

  // thermometer release: bits 0..stg are free in RELEASE, all free in RUN
  for (genvar i = 0; i < NUM_DOMAINS; i++) begin : g_dom
    assign domain_rst_d[i] = !((state_n == S_RUN) ||
                               ((state_n == S_RELEASE) && (SW'(i) <= stg_n)));
  end

endmodule

// File: tb/tb_clkrst_sequencer.sv
// tb_clkrst_sequencer
//   Directed bench for clkrst_sequencer with small timing parameters.
//   Expected values are queued when a step is set up and popped when the
//   DUT response is sampled.
module tb_clkrst_sequencer;
  localparam int ND = 3;

  logic          sys_clock = 1'b0;
  logic          rst, pll_locked, cfg_done;
  logic [1:0]    chip_req, chip;
  logic          cfg_start, pll_reset, ready, fault;
  logic [ND-1:0] domain_rst;

  always #5 sys_clock = ~sys_clock;

  clkrst_sequencer #(
    .NUM_DOMAINS(ND), .POR_BITS(4), .PLL_RST_CYC(4), .LOCK_FILTER(3),
    .LOCK_TIMEOUT(32), .MAX_RETRIES(2), .STAGE_DELAY(5), .CHIP_STABLE(8),
    .CHIP_DEFAULT(2'b01)
  ) dut (
    .sys_clock(sys_clock), .rst(rst), .chip_req(chip_req),
    .pll_locked(pll_locked), .cfg_done(cfg_done), .cfg_start(cfg_start),
    .pll_reset(pll_reset), .chip(chip), .domain_rst(domain_rst),
    .ready(ready), .fault(fault)
  );

  typedef struct { string tag; logic [31:0] val; } exp_t;
  exp_t sb[$];
  int vectors = 0, miscompares = 0;
  int cfg_pulses = 0;

  always @(posedge sys_clock) begin
    #1;
    if (cfg_start === 1'b1) cfg_pulses++;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge sys_clock);
  endtask

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL sb_empty: observed %0h, nothing expected", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        miscompares++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
      end
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0: return cfg_start;
      1: return ready;
      2: return fault;
      default: return pll_reset;
    endcase
  endfunction

  task automatic wait_sig(input int sel, input logic v, input int max, output int n);
    n = 0;
    while (sig(sel) !== v && n < max) begin tick(); n++; end
  endtask

  task automatic wait_dr_change(input int max, output int n);
    logic [ND-1:0] d0;
    d0 = domain_rst;
    n = 0;
    while (domain_rst === d0 && n < max) begin tick(); n++; end
  endtask

  task automatic wait_dr_val(input logic [ND-1:0] v, input int max, output int n);
    n = 0;
    while (domain_rst !== v && n < max) begin tick(); n++; end
  endtask

  task automatic pulse_done();
    cfg_done = 1'b1;
    tick();
    cfg_done = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n, m, p0, idx, l1, l2, l3;
  logic bad;
  logic pr[110];

  initial begin
    rst = 1'b1; chip_req = 2'b01; pll_locked = 1'b1; cfg_done = 1'b0;
    tick(3);
    // reset state
    push("rst_dom", 3'b111); push("rst_pll", 1); push("rst_cfg", 0);
    push("rst_rdy", 0); push("rst_flt", 0); push("rst_chip", 2'b01);
    check(domain_rst); check(pll_reset); check(cfg_start);
    check(ready); check(fault); check(chip);

    // power-up sequence
    rst = 1'b0;
    push("por_len", 8); wait_sig(0, 1'b1, 50, n); check(n);
    push("cfg_chip", 2'b01); check(chip);
    tick();
    push("cfg_once", 0); check(cfg_start);
    tick();
    pulse_done();
    push("rel0", 3'b110); wait_dr_change(50, n); check(domain_rst);
    push("gap1", 5); push("rel1", 3'b100);
    wait_dr_change(20, n); check(n); check(domain_rst);
    push("gap2", 5); push("rel2", 3'b000);
    wait_dr_change(20, n); check(n); check(domain_rst);
    push("rdy_gap", 5); wait_sig(1, 1'b1, 20, n); check(n);
    push("run_pll", 0); check(pll_reset);
    push("run_chip", 2'b01); check(chip);

    // 7-cycle chip glitch: ignored
    p0 = cfg_pulses;
    chip_req = 2'b10; tick(7); chip_req = 2'b01; tick(15);
    push("glitch_pulses", 0); check(cfg_pulses - p0);
    push("glitch_rdy", 1); check(ready);
    push("glitch_chip", 2'b01); check(chip);

    // 8-cycle stable change: reconfigure
    chip_req = 2'b10;
    push("chg_seen", 1); wait_sig(0, 1'b1, 30, n); check(cfg_start);
    push("chg_dom", 3'b111); check(domain_rst);
    push("chg_chip", 2'b10); check(chip);
    push("chg_rdy0", 0); check(ready);
    tick();
    pulse_done();
    push("chg_rdy", 1); wait_sig(1, 1'b1, 100, n); check(ready);
    push("chg_pulses", 1); check(cfg_pulses - p0);
    push("chg_dom_run", 3'b000); check(domain_rst);
    push("chg_chip_run", 2'b10); check(chip);

    // single-cycle lock drop in RUN
    p0 = cfg_pulses;
    pll_locked = 1'b0; tick(); pll_locked = 1'b1;
    wait_dr_val(3'b111, 10, m); n = m + 1;
    push("loss_lat_ok", 1); check({31'd0, (n >= 1 && n <= 3)});
    push("loss_rdy", 0); check(ready);
    push("loss_chip", 2'b10); check(chip);
    push("loss_back", 1); wait_sig(1, 1'b1, 100, n); check(ready);
    push("loss_pulses", 0); check(cfg_pulses - p0);
    push("loss_chip2", 2'b10); check(chip);

    // rst in the middle of RELEASE
    pll_locked = 1'b0; tick(); pll_locked = 1'b1;
    push("mid_rel", 3'b100); wait_dr_val(3'b100, 100, n); check(domain_rst);
    rst = 1'b1; chip_req = 2'b01;
    tick();
    push("rst5_dom", 3'b111); push("rst5_chip", 2'b01);
    push("rst5_rdy", 0); push("rst5_pll", 1);
    check(domain_rst); check(chip); check(ready); check(pll_reset);
    rst = 1'b0;
    push("por_len2", 8); wait_sig(0, 1'b1, 50, n); check(n);

    // lock toggling 1,1,0: never locks, two timeouts, then fault
    bad = 1'b0;
    for (int k = 0; k < 110; k++) begin
      pll_locked = (k % 3 != 2);
      cfg_done = (k == 6);
      tick();
      pr[k] = pll_reset;
      if (domain_rst !== 3'b111) bad = 1'b1;
    end
    cfg_done = 1'b0;
    idx = 0; l1 = 0; l2 = 0; l3 = 0;
    while (idx < 110 && pr[idx] !== 1'b0) idx++;
    while (idx < 110 && pr[idx] === 1'b0) begin l1++; idx++; end
    while (idx < 110 && pr[idx] === 1'b1) begin l2++; idx++; end
    while (idx < 110 && pr[idx] === 1'b0) begin l3++; idx++; end
    push("tog_wait1", 32); check(l1);
    push("tog_prst", 4); check(l2);
    push("tog_wait2", 32); check(l3);
    push("tog_held", 0); check({31'd0, bad});
    push("tog_fault", 1); check(fault);
    push("tog_pll", 1); check(pll_reset);

    // lock stuck low: fault timing and stickiness
    rst = 1'b1; pll_locked = 1'b0;
    tick();
    push("rst_clr_flt", 0); check(fault);
    rst = 1'b0;
    wait_sig(0, 1'b1, 50, n);
    tick();
    pulse_done();
    push("stuck_len", 72); wait_sig(2, 1'b1, 200, n); check(n);
    push("stuck_pll", 1); check(pll_reset);
    push("stuck_dom", 3'b111); check(domain_rst);
    push("stuck_rdy", 0); check(ready);
    pll_locked = 1'b1;
    tick(20);
    push("sticky", 1); check(fault);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    push("flt_clr", 0); check(fault);

    vectors++;
    assert (sb.size() == 0) else begin
      miscompares++;
      $error("FAIL sb_left: observed %0d expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
